// File: rtl/comp_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comp_scan_ctrl_pkg
//  Description : Shared types and constants for the comparator scan
//                sequencer: FSM state encoding, strip geometry, default
//                settle/timeout lengths and counter widths.
//  Revision    : 1.0  initial release
// ============================================================================
package comp_scan_ctrl_pkg;

    // Strip geometry
    localparam int NSTRIPS = 32;
    localparam int STRIP_W = 5;

    // Default timing parameters
    localparam int DEF_SETTLE_CYCLES  = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1023;

    // Counter widths sized for the allowed parameter ranges
    // (settle 1..255, timeout 1..1023)
    localparam int SETTLE_W = 8;
    localparam int WAIT_W   = 10;
    localparam int NPULSE_W = 16;

    // Scan FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEEK    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_FIRE    = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_WAIT_HI = 3'd5,
        ST_SAMPLE  = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

endpackage : comp_scan_ctrl_pkg
`default_nettype wire

// File: rtl/comp_scan_ctrl_strip_seek.sv
`default_nettype none
// ============================================================================
//  Module      : strip_seek
//  Description : Combinational finder for the lowest set bit of a strip mask
//                at or above a starting index.
//  Ports       : i_mask   - strip enable mask
//                i_from   - lowest index allowed in the search
//                o_idx    - index of the lowest qualifying set bit (0 if none)
//                o_found  - a qualifying set bit exists
//  Revision    : 1.0  initial release
// ============================================================================
module strip_seek
    import comp_scan_ctrl_pkg::*;
(
    input  logic [NSTRIPS-1:0] i_mask,
    input  logic [STRIP_W-1:0] i_from,
    output logic [STRIP_W-1:0] o_idx,
    output logic               o_found
);

    // Walk from the top down so the last hit written is the lowest index.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = NSTRIPS - 1; i >= 0; i--) begin
            if (i_mask[i] && (i >= int'(i_from))) begin
                o_found = 1'b1;
                o_idx   = STRIP_W'(i);
            end
        end
    end

endmodule : strip_seek
`default_nettype wire

// File: rtl/comp_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : comp_scan_ctrl
//  Description : Autonomous scan sequencer for the comparator test stand.
//                Visits each enabled half-strip in ascending order, drives
//                the one-hot expected pattern, fires the pulser npulses times
//                and counts halfstrip words that differ from the expectation.
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                start, abort         - scan launch / terminate strobes
//                npulses, strip_mask  - scan configuration, latched at start
//                pulser_ready         - pulser idle indication
//                halfstrips           - captured comparator word
//                fire_pulse           - single-cycle pulser trigger
//                halfstrips_expect    - one-hot of current strip while busy
//                cur_strip            - strip currently scanned
//                busy, done           - scan status
//                timeout_err          - sticky pulser handshake timeout
//                err_cnt              - saturating mismatch count
//                err_strip_mask       - strips with at least one mismatch
//  Revision    : 1.0  initial release
// ============================================================================
module comp_scan_ctrl
    import comp_scan_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [15:0]         npulses,
    input  logic [NSTRIPS-1:0]  strip_mask,
    input  logic                pulser_ready,
    input  logic [NSTRIPS-1:0]  halfstrips,
    output logic                fire_pulse,
    output logic [NSTRIPS-1:0]  halfstrips_expect,
    output logic [STRIP_W-1:0]  cur_strip,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    output logic [31:0]         err_cnt,
    output logic [NSTRIPS-1:0]  err_strip_mask
);

    localparam logic [SETTLE_W-1:0] C_SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [WAIT_W-1:0]   C_WAIT_LAST   = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STRIP_W-1:0]  C_LAST_STRIP  = STRIP_W'(NSTRIPS - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                r_state_q,      w_state_d;
    logic [STRIP_W-1:0]    r_cur_strip_q,  w_cur_strip_d;
    logic [NPULSE_W-1:0]   r_npulses_q,    w_npulses_d;
    logic [NSTRIPS-1:0]    r_mask_q,       w_mask_d;
    logic [NPULSE_W-1:0]   r_pulse_cnt_q,  w_pulse_cnt_d;
    logic [SETTLE_W-1:0]   r_settle_cnt_q, w_settle_cnt_d;
    logic [WAIT_W-1:0]     r_wait_cnt_q,   w_wait_cnt_d;
    logic                  r_done_q,       w_done_d;
    logic                  r_timeout_q,    w_timeout_d;
    logic [31:0]           r_err_cnt_q,    w_err_cnt_d;
    logic [NSTRIPS-1:0]    r_err_mask_q,   w_err_mask_d;

    logic                  w_fire;
    logic                  w_busy;
    logic [NSTRIPS-1:0]    w_expect;
    logic [NPULSE_W-1:0]   w_pulse_inc;
    logic [STRIP_W-1:0]    w_seek_idx;
    logic                  w_seek_found;

    // ------------------------------------------------------------------
    // Next enabled strip at or above the current one
    // ------------------------------------------------------------------
    strip_seek u_strip_seek (
        .i_mask  (r_mask_q),
        .i_from  (r_cur_strip_q),
        .o_idx   (w_seek_idx),
        .o_found (w_seek_found)
    );

    assign w_busy      = (r_state_q != ST_IDLE);
    assign w_expect    = w_busy ? (NSTRIPS'(1) << r_cur_strip_q) : '0;
    // The pulse count never reaches npulses before leaving the strip, so
    // this increment cannot wrap.
    assign w_pulse_inc = r_pulse_cnt_q + NPULSE_W'(1);

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d      = r_state_q;
        w_cur_strip_d  = r_cur_strip_q;
        w_npulses_d    = r_npulses_q;
        w_mask_d       = r_mask_q;
        w_pulse_cnt_d  = r_pulse_cnt_q;
        w_settle_cnt_d = r_settle_cnt_q;
        // Wait counter restarts on every state entry; only staying in a
        // handshake state advances it.
        w_wait_cnt_d   = '0;
        w_done_d       = r_done_q;
        w_timeout_d    = r_timeout_q;
        w_err_cnt_d    = r_err_cnt_q;
        w_err_mask_d   = r_err_mask_q;
        w_fire         = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_npulses_d   = npulses;
                    w_mask_d      = strip_mask;
                    w_err_cnt_d   = '0;
                    w_err_mask_d  = '0;
                    w_timeout_d   = 1'b0;
                    w_done_d      = 1'b0;
                    w_cur_strip_d = '0;
                    w_state_d     = ST_SEEK;
                end
            end

            ST_SEEK: begin
                if (!w_seek_found || (r_npulses_q == '0)) begin
                    w_state_d = ST_DONE;
                end else begin
                    w_cur_strip_d  = w_seek_idx;
                    w_settle_cnt_d = '0;
                    w_state_d      = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (r_settle_cnt_q == C_SETTLE_LAST) begin
                    w_pulse_cnt_d = '0;
                    w_state_d     = ST_FIRE;
                end else begin
                    w_settle_cnt_d = r_settle_cnt_q + SETTLE_W'(1);
                end
            end

            ST_FIRE: begin
                if (pulser_ready) begin
                    w_fire    = 1'b1;
                    w_state_d = ST_WAIT_LO;
                end else if (r_wait_cnt_q == C_WAIT_LAST) begin
                    w_timeout_d = 1'b1;
                    w_state_d   = ST_DONE;
                end else begin
                    w_wait_cnt_d = r_wait_cnt_q + WAIT_W'(1);
                end
            end

            ST_WAIT_LO: begin
                if (!pulser_ready) begin
                    w_state_d = ST_WAIT_HI;
                end else if (r_wait_cnt_q == C_WAIT_LAST) begin
                    w_timeout_d = 1'b1;
                    w_state_d   = ST_DONE;
                end else begin
                    w_wait_cnt_d = r_wait_cnt_q + WAIT_W'(1);
                end
            end

            ST_WAIT_HI: begin
                if (pulser_ready) begin
                    w_state_d = ST_SAMPLE;
                end else if (r_wait_cnt_q == C_WAIT_LAST) begin
                    w_timeout_d = 1'b1;
                    w_state_d   = ST_DONE;
                end else begin
                    w_wait_cnt_d = r_wait_cnt_q + WAIT_W'(1);
                end
            end

            ST_SAMPLE: begin
                if (halfstrips != w_expect) begin
                    if (r_err_cnt_q != '1) begin
                        w_err_cnt_d = r_err_cnt_q + 32'd1;
                    end
                    w_err_mask_d[r_cur_strip_q] = 1'b1;
                end
                w_pulse_cnt_d = w_pulse_inc;
                if (w_pulse_inc < r_npulses_q) begin
                    w_state_d = ST_FIRE;
                end else if (r_cur_strip_q == C_LAST_STRIP) begin
                    w_state_d = ST_DONE;
                end else begin
                    w_cur_strip_d = r_cur_strip_q + STRIP_W'(1);
                    w_state_d     = ST_SEEK;
                end
            end

            ST_DONE: begin
                w_done_d  = 1'b1;
                w_state_d = ST_IDLE;
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything else: drop straight to IDLE and keep
        // the results gathered so far intact.
        if (abort && w_busy) begin
            w_state_d      = ST_IDLE;
            w_cur_strip_d  = r_cur_strip_q;
            w_npulses_d    = r_npulses_q;
            w_mask_d       = r_mask_q;
            w_pulse_cnt_d  = r_pulse_cnt_q;
            w_settle_cnt_d = r_settle_cnt_q;
            w_wait_cnt_d   = '0;
            w_done_d       = r_done_q;
            w_timeout_d    = r_timeout_q;
            w_err_cnt_d    = r_err_cnt_q;
            w_err_mask_d   = r_err_mask_q;
            w_fire         = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= ST_IDLE;
            r_cur_strip_q  <= '0;
            r_npulses_q    <= '0;
            r_mask_q       <= '0;
            r_pulse_cnt_q  <= '0;
            r_settle_cnt_q <= '0;
            r_wait_cnt_q   <= '0;
            r_done_q       <= 1'b0;
            r_timeout_q    <= 1'b0;
            r_err_cnt_q    <= '0;
            r_err_mask_q   <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_cur_strip_q  <= w_cur_strip_d;
            r_npulses_q    <= w_npulses_d;
            r_mask_q       <= w_mask_d;
            r_pulse_cnt_q  <= w_pulse_cnt_d;
            r_settle_cnt_q <= w_settle_cnt_d;
            r_wait_cnt_q   <= w_wait_cnt_d;
            r_done_q       <= w_done_d;
            r_timeout_q    <= w_timeout_d;
            r_err_cnt_q    <= w_err_cnt_d;
            r_err_mask_q   <= w_err_mask_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The trigger is combinational from FIRE so it tracks pulser_ready in
    // the same cycle; reset masks it so no pulse escapes on a reset edge.
    assign fire_pulse        = w_fire && !reset;
    assign halfstrips_expect = w_expect;
    assign cur_strip         = r_cur_strip_q;
    assign busy              = w_busy;
    assign done              = r_done_q;
    assign timeout_err       = r_timeout_q;
    assign err_cnt           = r_err_cnt_q;
    assign err_strip_mask    = r_err_mask_q;

endmodule : comp_scan_ctrl
`default_nettype wire

// File: tb/tb_comp_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comp_scan_ctrl
//  Description : Scoreboard bench for comp_scan_ctrl. Directed scans push the
//                expected pulse strips and end-of-scan results into queues; a
//                negedge monitor pops and compares on each fire_pulse and on
//                each busy falling edge. A pulser model answers handshakes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_comp_scan_ctrl;

    typedef struct {
        logic [31:0] err_cnt;
        logic [31:0] emask;
        logic        to;
        logic        done;
        int          fires;
    } res_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] npulses;
    logic [31:0] strip_mask;
    logic        pulser_ready;
    logic [31:0] halfstrips;
    logic        fire_pulse;
    logic [31:0] halfstrips_expect;
    logic [4:0]  cur_strip;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [31:0] err_cnt;
    logic [31:0] err_strip_mask;

    logic [31:0] bad_strips;
    logic        stuck;

    int   total;
    int   bad;
    int   fires;
    logic prev_busy;
    int   fire_q[$];
    res_t exp_q[$];

    comp_scan_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .npulses           (npulses),
        .strip_mask        (strip_mask),
        .pulser_ready      (pulser_ready),
        .halfstrips        (halfstrips),
        .fire_pulse        (fire_pulse),
        .halfstrips_expect (halfstrips_expect),
        .cur_strip         (cur_strip),
        .busy              (busy),
        .done              (done),
        .timeout_err       (timeout_err),
        .err_cnt           (err_cnt),
        .err_strip_mask    (err_strip_mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Comparator model: echoes the one-hot of the strip under test unless
    // that strip is marked bad, in which case it reports nothing.
    always_comb begin
        halfstrips = 32'h0;
        if (busy && !bad_strips[cur_strip]) halfstrips = 32'h1 << cur_strip;
    end

    // Pulser model: ready drops after a trigger and returns two cycles later.
    initial begin
        pulser_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (fire_pulse && !stuck) begin
                @(posedge clk);
                #1 pulser_ready = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1 pulser_ready = 1'b1;
            end
        end
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push_res(logic [31:0] e, logic [31:0] m, logic t, logic d, int f);
        res_t r;
        r.err_cnt = e;
        r.emask   = m;
        r.to      = t;
        r.done    = d;
        r.fires   = f;
        exp_q.push_back(r);
    endfunction

    // Monitor
    initial begin
        res_t r;
        int   s;
        prev_busy = 1'b0;
        fires     = 0;
        forever begin
            @(negedge clk);
            if (fire_pulse) begin
                fires++;
                check("fire_handshake", {31'b0, pulser_ready}, 32'h1);
                if (fire_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL fire_unexpected: strip %0d fired with none expected", cur_strip);
                end else begin
                    s = fire_q.pop_front();
                    check("fire_strip", {27'b0, cur_strip}, s);
                    check("fire_expect", halfstrips_expect, 32'h1 << s);
                end
            end
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL res_unexpected: scan ended with no expected result");
                end else begin
                    r = exp_q.pop_front();
                    check("res_done", {31'b0, done}, {31'b0, r.done});
                    check("res_timeout", {31'b0, timeout_err}, {31'b0, r.to});
                    check("res_err_cnt", err_cnt, r.err_cnt);
                    check("res_err_mask", err_strip_mask, r.emask);
                    check("res_fires", fires, r.fires);
                    check("res_expect_idle", halfstrips_expect, 32'h0);
                end
                fires = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic start_scan(input logic [31:0] m, input logic [15:0] n);
        @(negedge clk);
        strip_mask = m;
        npulses    = n;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", {31'b0, busy}, 32'h1);
    endtask

    task automatic wait_idle(input int limit, output int cyc);
        cyc = 1;
        while (busy && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", cyc);
        end
    endtask

    initial begin
        int cyc;
        int n;
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        npulses    = 16'd0;
        strip_mask = 32'h0;
        bad_strips = 32'h0;
        stuck      = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset values
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_fire", {31'b0, fire_pulse}, 32'h0);
        check("rst_timeout", {31'b0, timeout_err}, 32'h0);
        check("rst_err_cnt", err_cnt, 32'h0);
        check("rst_err_mask", err_strip_mask, 32'h0);
        check("rst_expect", halfstrips_expect, 32'h0);
        check("rst_cur_strip", {27'b0, cur_strip}, 32'h0);

        // Single strip, three clean pulses
        fire_q = '{0, 0, 0};
        push_res(32'h0, 32'h0, 1'b0, 1'b1, 3);
        start_scan(32'h0000_0001, 16'd3);
        wait_idle(2000, cyc);

        // Sparse mask, strip 2 mismatches on both pulses
        bad_strips = 32'h0000_0004;
        fire_q = '{0, 0, 2, 2, 31, 31};
        push_res(32'd2, 32'h0000_0004, 1'b0, 1'b1, 6);
        start_scan(32'h8000_0005, 16'd2);
        wait_idle(3000, cyc);
        bad_strips = 32'h0;

        // Degenerate: empty mask
        push_res(32'h0, 32'h0, 1'b0, 1'b1, 0);
        start_scan(32'h0, 16'd5);
        wait_idle(20, cyc);
        check("degen_mask_latency_ok", {31'b0, (cyc <= 3)}, 32'h1);

        // Degenerate: zero pulses
        push_res(32'h0, 32'h0, 1'b0, 1'b1, 0);
        start_scan(32'h0000_000F, 16'd0);
        wait_idle(20, cyc);
        check("degen_np_latency_ok", {31'b0, (cyc <= 3)}, 32'h1);

        // Timeout: ready never drops after the first trigger
        stuck  = 1'b1;
        fire_q = '{0};
        push_res(32'h0, 32'h0, 1'b1, 1'b1, 1);
        start_scan(32'h0000_0001, 16'd2);
        wait_idle(3000, cyc);
        stuck = 1'b0;

        // Abort during WAIT_HI on strip 5; strip 0 failed both pulses
        bad_strips = 32'h0000_0001;
        fire_q = '{0, 0, 5};
        push_res(32'd2, 32'h0000_0001, 1'b0, 1'b0, 3);
        start_scan(32'h0000_0021, 16'd2);
        n = 0;
        while (!(fire_pulse && cur_strip == 5'd5) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL abort_wait: strip 5 never fired, required a fire");
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", {31'b0, busy}, 32'h0);
        repeat (3) @(negedge clk);
        check("abort_hold_cnt", err_cnt, 32'd2);
        check("abort_hold_mask", err_strip_mask, 32'h0000_0001);
        check("abort_done", {31'b0, done}, 32'h0);
        bad_strips = 32'h0;

        // New start clears results held from the aborted scan
        push_res(32'h0, 32'h0, 1'b0, 1'b1, 0);
        start_scan(32'h0, 16'd1);
        check("restart_clr_cnt", err_cnt, 32'h0);
        check("restart_clr_mask", err_strip_mask, 32'h0);
        wait_idle(20, cyc);

        // Reset during SETTLE of strip 2 after a failing strip 0
        bad_strips = 32'h0000_0001;
        fire_q = '{0};
        push_res(32'h0, 32'h0, 1'b0, 1'b0, 1);
        start_scan(32'h0000_0005, 16'd1);
        n = 0;
        while (cur_strip != 5'd2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_err", err_cnt, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_cur_strip", {27'b0, cur_strip}, 32'h0);
        check("mid_rst_err_cnt", err_cnt, 32'h0);
        check("mid_rst_err_mask", err_strip_mask, 32'h0);
        check("mid_rst_expect", halfstrips_expect, 32'h0);
        bad_strips = 32'h0;

        // Saturation: preload the count just below max, then three failures
        bad_strips = 32'h0000_0001;
        fire_q = '{0, 0, 0};
        push_res(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 3);
        start_scan(32'h0000_0001, 16'd3);
        repeat (3) @(negedge clk);
        force dut.r_err_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.r_err_cnt_q;
        wait_idle(2000, cyc);
        bad_strips = 32'h0;

        repeat (5) @(negedge clk);
        check("fire_q_drained", fire_q.size(), 32'h0);
        check("res_q_drained", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_comp_scan_ctrl
`default_nettype wire
